// File: rtl/cpu_oci_trace_pkg.sv
// Shared types, defaults and helpers for the OCI trace collector.
package cpu_oci_trace_pkg;

    localparam int unsigned DEF_SLOT_W = 10;
    localparam int unsigned DEF_SLOTS  = 3;
    localparam int unsigned DEF_CNT_W  = 4;
    localparam int unsigned DEF_DEPTH  = 16;
    localparam int unsigned DEF_STAT_W = 16;

    typedef enum logic [1:0] {
        StAccept = 2'd0,
        StFlush  = 2'd1,
        StDone   = 2'd2
    } trace_state_e;

    // Increment that sticks at max_value instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input logic [31:0] max_value);
        return (value >= max_value) ? max_value : value + 32'd1;
    endfunction

endpackage

// File: rtl/cpu_oci_trace_collector_if.sv
// Trace capture, output stream and status signals of the collector.
// Optional macro TRACE_CHECKSUM_EN adds the checksum signal.
interface cpu_oci_trace_collector_if
    import cpu_oci_trace_pkg::*;
#(
    parameter int unsigned SLOT_W = DEF_SLOT_W,
    parameter int unsigned SLOTS  = DEF_SLOTS,
    parameter int unsigned CNT_W  = DEF_CNT_W,
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned STAT_W = DEF_STAT_W
);

    logic                      dct_valid;
    logic [SLOTS*SLOT_W-1:0]   dct_buffer;
    logic [CNT_W-1:0]          dct_count;
    logic                      test_ending;
    logic                      test_has_ended;
    logic                      out_valid;
    logic [SLOT_W-1:0]         out_data;
    logic                      out_ready;
    logic [$clog2(DEPTH):0]    fill_level;
    logic [STAT_W-1:0]         entry_cnt;
    logic [STAT_W-1:0]         drop_cnt;
    logic                      count_err;
    logic                      done;
`ifdef TRACE_CHECKSUM_EN
    logic [SLOT_W-1:0]         checksum;

    modport master (
        output dct_valid, dct_buffer, dct_count, test_ending, test_has_ended, out_ready,
        input  out_valid, out_data, fill_level, entry_cnt, drop_cnt, count_err, done, checksum
    );

    modport slave (
        input  dct_valid, dct_buffer, dct_count, test_ending, test_has_ended, out_ready,
        output out_valid, out_data, fill_level, entry_cnt, drop_cnt, count_err, done, checksum
    );
`else
    modport master (
        output dct_valid, dct_buffer, dct_count, test_ending, test_has_ended, out_ready,
        input  out_valid, out_data, fill_level, entry_cnt, drop_cnt, count_err, done
    );

    modport slave (
        input  dct_valid, dct_buffer, dct_count, test_ending, test_has_ended, out_ready,
        output out_valid, out_data, fill_level, entry_cnt, drop_cnt, count_err, done
    );
`endif

endinterface

// File: rtl/cpu_oci_trace_fifo.sv
// First-word-fall-through slot FIFO with occupancy output.
module cpu_oci_trace_fifo
    import cpu_oci_trace_pkg::*;
#(
    parameter int unsigned SLOT_W = DEF_SLOT_W,
    parameter int unsigned DEPTH  = DEF_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en_i,
    input  logic [SLOT_W-1:0]      wr_data_i,
    input  logic                   rd_en_i,
    output logic [SLOT_W-1:0]      rd_data_o,
    output logic                   valid_o,
    output logic [$clog2(DEPTH):0] fill_level_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [SLOT_W-1:0] mem_q [DEPTH];
    logic [SLOT_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    fill_q, fill_d;
    logic              do_rd;

    // Pointer, storage and occupancy update; writer guarantees free space.
    always_comb begin
        do_rd    = rd_en_i && (fill_q != '0);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        if (wr_en_i) begin
            mem_d[wr_ptr_q] = wr_data_i;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({wr_en_i, do_rd})
            2'b10:   fill_d = fill_q + 1'b1;
            2'b01:   fill_d = fill_q - 1'b1;
            default: fill_d = fill_q;
        endcase
    end

    // Storage array needs no reset; only the pointers define its contents.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
        end
    end

    assign rd_data_o    = mem_q[rd_ptr_q];
    assign valid_o      = (fill_q != '0);
    assign fill_level_o = fill_q;

endmodule

// File: rtl/cpu_oci_trace_collector.sv
// OCI DCT trace collector: unpacks packed trace words into slots, buffers
// them and streams them out; test_ending/test_has_ended flush then finish.
// Optional macro TRACE_CHECKSUM_EN adds a running XOR of popped slots.
module cpu_oci_trace_collector
    import cpu_oci_trace_pkg::*;
#(
    parameter int unsigned SLOT_W = DEF_SLOT_W,
    parameter int unsigned SLOTS  = DEF_SLOTS,
    parameter int unsigned CNT_W  = DEF_CNT_W,
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned STAT_W = DEF_STAT_W
) (
    input logic                   clk,
    input logic                   reset,
    cpu_oci_trace_collector_if.slave bus
);

    localparam int unsigned FILL_W = $clog2(DEPTH) + 1;
    localparam int unsigned REM_W  = $clog2(SLOTS + 1);
    localparam logic [1:0]  ST_ACCEPT = 2'(StAccept);
    localparam logic [1:0]  ST_FLUSH  = 2'(StFlush);
    localparam logic [1:0]  ST_DONE   = 2'(StDone);
    localparam logic [31:0] STAT_MAX  = (STAT_W >= 32) ? 32'hFFFF_FFFF
                                                       : ((32'd1 << STAT_W) - 32'd1);

    logic [1:0]              state_q, state_d;
    logic                    has_ended_q, has_ended_d;
    logic [SLOTS*SLOT_W-1:0] word_q, word_d;
    logic [REM_W-1:0]        rem_q, rem_d;
    logic [STAT_W-1:0]       entry_cnt_q, entry_cnt_d;
    logic [STAT_W-1:0]       drop_cnt_q, drop_cnt_d;
    logic                    count_err_q, count_err_d;

    logic [CNT_W-1:0]        cnt;
    logic                    over_count;
    int unsigned             eff_count;
    int unsigned             free_slots;
    logic                    unpack_idle;
    logic                    word_seen;
    logic                    accept_ok;
    logic                    fifo_wr;
    logic                    fifo_valid;
    logic                    pop;
    logic [SLOT_W-1:0]       fifo_rdata;
    logic [FILL_W-1:0]       fill_level;

    assign cnt = bus.dct_count;
    assign pop = fifo_valid && bus.out_ready;

    // Accept decision: space for the whole clamped word must be free now.
    always_comb begin
        over_count  = 32'(cnt) > SLOTS;
        eff_count   = over_count ? SLOTS : 32'(cnt);
        free_slots  = DEPTH - 32'(fill_level);
        unpack_idle = (rem_q == '0);
        word_seen   = bus.dct_valid && (state_q == ST_ACCEPT);
        accept_ok   = (state_q == ST_ACCEPT) && unpack_idle && (free_slots >= eff_count);
    end

    // Unpacker: one slot per cycle from the LSBs, then shift the word down.
    always_comb begin
        word_d  = word_q;
        rem_d   = rem_q;
        fifo_wr = 1'b0;
        if (!unpack_idle) begin
            fifo_wr = 1'b1;
            word_d  = word_q >> SLOT_W;
            rem_d   = rem_q - 1'b1;
        end else if (word_seen && accept_ok) begin
            word_d = bus.dct_buffer;
            rem_d  = REM_W'(eff_count);
        end
    end

    // Statistics: slots written, words dropped, sticky oversize count.
    always_comb begin
        entry_cnt_d = entry_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        count_err_d = count_err_q;
        if (fifo_wr) begin
            entry_cnt_d = STAT_W'(sat_inc(32'(entry_cnt_q), STAT_MAX));
        end
        if (word_seen && !accept_ok) begin
            drop_cnt_d = STAT_W'(sat_inc(32'(drop_cnt_q), STAT_MAX));
        end
        if (word_seen && over_count) begin
            count_err_d = 1'b1;
        end
    end

    // End-of-test sequencing: stop accepting, drain, then report done.
    always_comb begin
        state_d     = state_q;
        has_ended_d = has_ended_q | bus.test_has_ended;
        case (state_q)
            ST_ACCEPT: begin
                if (bus.test_ending || bus.test_has_ended) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (unpack_idle && (fill_level == '0) && has_ended_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_DONE;
            default:  state_d = ST_ACCEPT;
        endcase
    end

    // All collector state, synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_ACCEPT;
            has_ended_q <= 1'b0;
            word_q      <= '0;
            rem_q       <= '0;
            entry_cnt_q <= '0;
            drop_cnt_q  <= '0;
            count_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            has_ended_q <= has_ended_d;
            word_q      <= word_d;
            rem_q       <= rem_d;
            entry_cnt_q <= entry_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            count_err_q <= count_err_d;
        end
    end

`ifdef TRACE_CHECKSUM_EN
    logic [SLOT_W-1:0] checksum_q, checksum_d;

    // Running XOR of popped slots, frozen once done.
    always_comb begin
        checksum_d = checksum_q;
        if (pop && (state_q != ST_DONE)) begin
            checksum_d = checksum_q ^ fifo_rdata;
        end
    end

    // Checksum register.
    always_ff @(posedge clk) begin
        if (reset) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign bus.checksum = checksum_q;
`endif

    cpu_oci_trace_fifo #(
        .SLOT_W (SLOT_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .wr_en_i      (fifo_wr),
        .wr_data_i    (word_q[SLOT_W-1:0]),
        .rd_en_i      (bus.out_ready),
        .rd_data_o    (fifo_rdata),
        .valid_o      (fifo_valid),
        .fill_level_o (fill_level)
    );

    assign bus.out_valid  = fifo_valid;
    assign bus.out_data   = fifo_rdata;
    assign bus.fill_level = fill_level;
    assign bus.entry_cnt  = entry_cnt_q;
    assign bus.drop_cnt   = drop_cnt_q;
    assign bus.count_err  = count_err_q;
    assign bus.done       = (state_q == ST_DONE);

endmodule

// File: doc/cpu_oci_trace_collector.md
Name: cpu_oci_trace_collector

Overview:
- Parametrised successor to the OCI test-bench sink. It captures packed DCT trace words from the CPU OCI, unpacks them into individual slots and buffers them in a FIFO.
- Slots are drained on a valid/ready stream to a simulation monitor or trace port.
- The test_ending / test_has_ended handshake flushes the FIFO, then signals done.

Parameters:
- SLOT_W, 10, bits per trace slot
- SLOTS, 3, slots per dct_buffer word (dct_buffer width = SLOTS*SLOT_W)
- CNT_W, 4, width of dct_count
- DEPTH, 16, FIFO depth in slots; power of 2, >= SLOTS
- STAT_W, 16, width of statistics counters

Ports:
- clk  in  1  single clock
- reset  in  1  synchronous, active-high reset
- dct_valid  in  1  dct_buffer/dct_count qualifier, one-cycle pulse per word; cannot be backpressured
- dct_buffer  in  SLOTS*SLOT_W  packed slots; slot 0 in LSBs
- dct_count  in  CNT_W  number of valid slots in the word (0..SLOTS)
- test_ending  in  1  begin flush
- test_has_ended  in  1  test finished
- out_valid  out  1  out_data valid
- out_data  out  SLOT_W  head-of-FIFO slot
- out_ready  in  1  consumer accepts when out_valid&out_ready
- fill_level  out  $clog2(DEPTH)+1  slots held in the FIFO
- entry_cnt  out  STAT_W  slots written to the FIFO (saturating)
- drop_cnt  out  STAT_W  dct words dropped (saturating)
- count_err  out  1  sticky: dct_count > SLOTS was seen
- done  out  1  flush complete

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (also when asserted mid-operation): FIFO emptied, unpacker idle, state ACCEPT. All outputs 0: out_valid, fill_level, entry_cnt, drop_cnt, count_err, done.
- States:
  - ACCEPT -> FLUSH on test_ending | test_has_ended.
  - FLUSH -> DONE when unpacker idle & FIFO empty & has_ended_latched.
  - DONE holds until reset.
- has_ended_latched: sticky capture of test_has_ended from any state.
- Accept condition, evaluated in the dct_valid cycle: state==ACCEPT & unpacker idle & (DEPTH - fill_level) >= eff_count.
  - eff_count = min(dct_count, SLOTS).
  - On accept, the word and eff_count are registered into the unpacker.
  - If dct_valid is high in ACCEPT and the condition fails, the whole word is dropped and drop_cnt increments. There are no partial writes.
  - dct_valid in FLUSH/DONE is ignored and not counted.
- dct_count > SLOTS: treated as SLOTS; count_err set, sticky.
- dct_count == 0: accepted as a no-op; unpacker stays idle, no counters change.
- Unpacker:
  - Writes one slot per cycle, slot 0 first, into the FIFO.
  - entry_cnt increments per slot written.
  - Unpacker becomes idle in the cycle after its last write, so back-to-back words accept at most every eff_count+1 cycles.
  - No overflow is possible, because free space was reserved at accept.
- Latency: word accepted at cycle t -> slot 0 written at t+1 -> out_valid=1 with slot 0 at t+2 if the FIFO was empty (FWFT, registered).
- FIFO:
  - A simultaneous read and write leaves fill_level unchanged.
  - Pointers wrap modulo DEPTH; fill_level reaches DEPTH exactly when full.
  - out_data holds stable while out_valid & !out_ready.
- Counters saturate at 2^STAT_W-1.
- done=1 registered in DONE. FIFO draining continues during FLUSH regardless of has_ended.

Optional Feature:
- TRACE_CHECKSUM_EN defined: adds output checksum [SLOT_W-1:0].
  - Running XOR of every slot popped (out_valid&out_ready); reset to 0.
  - Frozen once done=1.
- Not defined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Package cpu_oci_trace_pkg: state enum (ACCEPT, FLUSH, DONE), saturating-increment function, default parameter constants.
- Sub-module cpu_oci_trace_fifo: parametrised FWFT FIFO (SLOT_W x DEPTH) with fill_level output.
- Unpacker, state machine and counters stay in the top.

Test Plan:
- Word 0x2AB_155_3FF, count 3, out_ready=1 -> out_data 0x3FF@t+2, 0x155@t+3, 0x2AB@t+4; entry_cnt=3.
- out_ready=0, six count-3 words spaced 4 cycles -> first five accepted (fill 15), sixth dropped (free 1 < 3); drop_cnt=1, fill_level=15.
- count=7 with SLOTS=3 -> 3 slots written, count_err=1 and stays 1; count=0 -> nothing written, no counter change.
- 8 slots buffered, test_ending pulse, test_has_ended 2 cycles later, out_ready=1 -> dct_valid ignored, all 8 slots drained in order, done=1 the cycle after the FIFO empties.
- Reset asserted mid-unpack with fill_level=5 -> next cycle fill_level=0, out_valid=0, all counters 0, state ACCEPT.
- (TRACE_CHECKSUM_EN) pop 0x001, 0x3FF, 0x155 -> checksum=0x2AB.
